// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcodes, control-word bit
// positions and the instruction-sequencer state encoding.
package cpu_pkg;

   // Opcode map
   localparam logic [5:0] OP_BRZ = 6'd0;
   localparam logic [5:0] OP_BRN = 6'd1;
   localparam logic [5:0] OP_BRC = 6'd2;
   localparam logic [5:0] OP_BRO = 6'd3;
   localparam logic [5:0] OP_LD  = 6'd4;
   localparam logic [5:0] OP_ST  = 6'd5;
   localparam logic [5:0] OP_MOV = 6'd6;
   localparam logic [5:0] OP_BRA = 6'd7;
   localparam logic [5:0] OP_JMP = 6'd8;
   localparam logic [5:0] OP_ADD = 6'd9;
   localparam logic [5:0] OP_SUB = 6'd10;
   localparam logic [5:0] OP_ADC = 6'd11;
   localparam logic [5:0] OP_SBC = 6'd12;
   localparam logic [5:0] OP_AND = 6'd13;
   localparam logic [5:0] OP_OR  = 6'd14;
   localparam logic [5:0] OP_XOR = 6'd15;
   localparam logic [5:0] OP_MUL = 6'd16;
   localparam logic [5:0] OP_DIV = 6'd17;
   localparam logic [5:0] OP_MOD = 6'd18;
   localparam logic [5:0] OP_SHL = 6'd19;
   localparam logic [5:0] OP_SHR = 6'd20;
   localparam logic [5:0] OP_NOT = 6'd21;
   localparam logic [5:0] OP_RET = 6'd22;
   localparam logic [5:0] OP_CMP = 6'd23;
   localparam logic [5:0] OP_TST = 6'd24;
   localparam logic [5:0] OP_INC = 6'd25;
   localparam logic [5:0] OP_DEC = 6'd26;

   // Control-word bit positions
   localparam int CTRL_NEXT  = 7;
   localparam int CTRL_BR    = 6;
   localparam int CTRL_ALUOP = 5;
   localparam int CTRL_LSE   = 4;
   localparam int CTRL_LDM   = 3;
   localparam int CTRL_LACC  = 2;
   localparam int CTRL_ABS   = 1;
   localparam int CTRL_SPO   = 0;

   // Decoder output for an opcode it does not recognise
   localparam logic [7:0] CTRL_ILLEGAL = 8'hFF;

   // Sequencer states
   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_FETCH    = 3'd1,
      ST_DECODE   = 3'd2,
      ST_EXEC     = 3'd3,
      ST_WAIT_ALU = 3'd4,
      ST_MEM      = 3'd5,
      ST_WB       = 3'd6,
      ST_HALT     = 3'd7
   } state_t;

endpackage

// File: rtl/branch_cond.sv
// Conditional-branch flag selector: brz/brn/brc/bro test Z/N/C/O, which sit
// at flags[0..3] in the same order as the low two opcode bits.
module branch_cond (
   input  logic [1:0] sel,
   input  logic [3:0] flags,
   output logic       taken
);

   assign taken = flags[sel];

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction-cycle controller for the accumulator CPU.
//
// Handshakes: instr_valid, alu_done and mem_ack are single-bit "done"
// indications that are only looked at in the state that owns them (FETCH,
// WAIT_ALU, MEM); the sequencer holds its request (fetch_req, mem_rd/mem_wr)
// steady until the matching indication is seen, and the completing cycle
// is the cycle the indication is high. start is only looked at in IDLE.
module instr_sequencer
   import cpu_pkg::*;
#(
   parameter int OPC_W    = 6,
   parameter int CTRL_W   = 8,
   parameter int MAX_WAIT = 32,
   parameter int RET_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              instr_valid,
   input  logic [OPC_W-1:0]  opCode,
   input  logic [CTRL_W-1:0] ctrl,
   input  logic [3:0]        flags,
   input  logic              alu_done,
   input  logic              mem_ack,
   output logic              fetch_req,
   output logic              ir_load,
   output logic              pc_inc,
   output logic              pc_load,
   output logic              sp_op,
   output logic              alu_start,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic              acc_load,
   output logic              halted,
   output logic              err,
   output logic [2:0]        state,
   output logic [RET_W-1:0]  retired
);

   localparam int CNT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;

   state_t            state_q;
   logic [OPC_W-1:0]  op_q;
   logic [CTRL_W-1:0] ctrl_q;
   logic [CNT_W-1:0]  wait_cnt;
   logic              retire;
   logic              taken;

   // Instruction-class decode of the latched instruction
   logic is_illegal, is_branch, is_cond, is_mem, is_load, is_long, no_acc;
   assign is_illegal = (ctrl_q == CTRL_W'(CTRL_ILLEGAL));
   assign is_branch  = !is_illegal && ctrl_q[CTRL_BR] && !ctrl_q[CTRL_ALUOP]
                       && !ctrl_q[CTRL_LDM];
   assign is_cond    = (op_q <= OPC_W'(OP_BRO));
   assign is_load    = ctrl_q[CTRL_LDM];
   assign is_mem     = is_load || (op_q == OPC_W'(OP_ST));
   assign is_long    = (op_q == OPC_W'(OP_MUL)) || (op_q == OPC_W'(OP_DIV))
                       || (op_q == OPC_W'(OP_MOD));
   assign no_acc     = (op_q == OPC_W'(OP_CMP)) || (op_q == OPC_W'(OP_TST));

   // next, lacc and abs steer other datapath blocks, not the sequencer
   logic unused_ctrl;
   assign unused_ctrl = &{1'b0, ctrl_q[CTRL_NEXT], ctrl_q[CTRL_LACC],
                          ctrl_q[CTRL_ABS]};

   branch_cond u_branch_cond (
      .sel   (op_q[1:0]),
      .flags (flags),
      .taken (taken)
   );

   assign state = state_q;

   // Phase strobes decoded from the current state and the latched instruction
   always_comb begin
      fetch_req = 1'b0;
      ir_load   = 1'b0;
      pc_inc    = 1'b0;
      pc_load   = 1'b0;
      sp_op     = 1'b0;
      alu_start = 1'b0;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      acc_load  = 1'b0;
      halted    = 1'b0;
      retire    = 1'b0;
      case (state_q)
         ST_FETCH: begin
            fetch_req = 1'b1;
            ir_load   = instr_valid;
         end
         ST_DECODE: begin
            if (is_branch) begin
               if (is_cond && !taken) pc_inc = 1'b1;
               else                   pc_load = 1'b1;
               sp_op  = ctrl_q[CTRL_SPO];
               retire = 1'b1;
            end
         end
         ST_EXEC: alu_start = 1'b1;
         ST_MEM: begin
            mem_rd = is_load;
            mem_wr = !is_load;
            if (mem_ack && !is_load) begin
               pc_inc = 1'b1;
               retire = 1'b1;
            end
         end
         ST_WB: begin
            acc_load = !no_acc;
            pc_inc   = 1'b1;
            retire   = 1'b1;
         end
         ST_HALT: halted = 1'b1;
         default: ;
      endcase
   end

   // Sequencer state, latched instruction, ALU wait counter, error and retire count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         op_q     <= '0;
         ctrl_q   <= '0;
         wait_cnt <= '0;
         err      <= 1'b0;
         retired  <= '0;
      end else begin
         if (retire) retired <= retired + 1'b1;
         case (state_q)
            ST_IDLE: if (start) state_q <= ST_FETCH;
            ST_FETCH: begin
               if (instr_valid) begin
                  op_q    <= opCode;
                  ctrl_q  <= ctrl;
                  state_q <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               if (is_illegal) begin
                  err     <= 1'b1;
                  state_q <= ST_HALT;
               end else if (is_branch)         state_q <= ST_FETCH;
               else if (is_mem)                state_q <= ST_MEM;
               else if (ctrl_q[CTRL_ALUOP])    state_q <= ST_EXEC;
               else                            state_q <= ST_WB;
            end
            ST_EXEC: begin
               if (is_long) begin
                  wait_cnt <= '0;
                  state_q  <= ST_WAIT_ALU;
               end else begin
                  state_q  <= ST_WB;
               end
            end
            ST_WAIT_ALU: begin
               wait_cnt <= wait_cnt + 1'b1;
               if (alu_done) begin
                  state_q <= ST_WB;
               end else if (wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
                  err     <= 1'b1;
                  state_q <= ST_HALT;
               end
            end
            ST_MEM: if (mem_ack) state_q <= is_load ? ST_WB : ST_FETCH;
            ST_WB:   state_q <= ST_FETCH;
            ST_HALT: state_q <= ST_HALT;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed instructions with hand-written expected
// strobe events pushed to a queue, and a monitor that pops one entry every
// cycle any phase strobe is active.
module tb_instr_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        instr_valid = 1'b0;
   logic [5:0]  opCode = '0;
   logic [7:0]  ctrl = '0;
   logic [3:0]  flags = '0;
   logic        alu_done = 1'b0;
   logic        mem_ack = 1'b0;
   logic        fetch_req, ir_load, pc_inc, pc_load, sp_op, alu_start;
   logic        mem_rd, mem_wr, acc_load, halted, err;
   logic [2:0]  state;
   logic [15:0] retired;

   int checks   = 0;
   int failures = 0;
   int wait_seen = 0;

   // strobe bits: {ir_load, pc_inc, pc_load, sp_op, alu_start, mem_rd, mem_wr, acc_load}
   localparam logic [7:0] S_IR  = 8'h80;
   localparam logic [7:0] S_PCI = 8'h40;
   localparam logic [7:0] S_PCL = 8'h20;
   localparam logic [7:0] S_SP  = 8'h10;
   localparam logic [7:0] S_ALU = 8'h08;
   localparam logic [7:0] S_RD  = 8'h04;
   localparam logic [7:0] S_WR  = 8'h02;
   localparam logic [7:0] S_ACC = 8'h01;

   // entry: {state[2:0], strobes[7:0], retired[15:0]}
   logic [26:0] exp_q[$];

   instr_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .instr_valid (instr_valid),
      .opCode      (opCode),
      .ctrl        (ctrl),
      .flags       (flags),
      .alu_done    (alu_done),
      .mem_ack     (mem_ack),
      .fetch_req   (fetch_req),
      .ir_load     (ir_load),
      .pc_inc      (pc_inc),
      .pc_load     (pc_load),
      .sp_op       (sp_op),
      .alu_start   (alu_start),
      .mem_rd      (mem_rd),
      .mem_wr      (mem_wr),
      .acc_load    (acc_load),
      .halted      (halted),
      .err         (err),
      .state       (state),
      .retired     (retired)
   );

   // clock
   always #5 clk = ~clk;

   // watchdog
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // counts cycles spent in WAIT_ALU
   always @(negedge clk) begin
      if (!rst && state == 3'd4) wait_seen <= wait_seen + 1;
   end

   // monitor: every cycle with an active strobe consumes one expected entry
   always @(negedge clk) begin
      logic [7:0]  strb;
      logic [26:0] act;
      logic [26:0] exp_e;
      if (!rst) begin
         strb = {ir_load, pc_inc, pc_load, sp_op, alu_start, mem_rd, mem_wr, acc_load};
         if (strb != 8'h00) begin
            act = {state, strb, retired};
            checks = checks + 1;
            if (exp_q.size() == 0) begin
               failures = failures + 1;
               $display("FAIL strobe_event: unexpected st=%0d strb=%02h ret=%0d, required no strobe",
                        state, strb, retired);
            end else begin
               exp_e = exp_q.pop_front();
               if (act !== exp_e) begin
                  failures = failures + 1;
                  $display("FAIL strobe_event: actual st=%0d strb=%02h ret=%0d required st=%0d strb=%02h ret=%0d",
                           act[26:24], act[23:16], act[15:0],
                           exp_e[26:24], exp_e[23:16], exp_e[15:0]);
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks = checks + 1;
      if (act !== req) begin
         failures = failures + 1;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic push(input logic [2:0] st, input logic [7:0] s, input logic [15:0] r);
      exp_q.push_back({st, s, r});
   endtask

   // all outputs packed: {fetch_req..err(11), state(3), retired(16)}
   function automatic logic [29:0] all_out();
      return {fetch_req, ir_load, pc_inc, pc_load, sp_op, alu_start, mem_rd,
              mem_wr, acc_load, halted, err, state, retired};
   endfunction

   // from IDLE (called at posedge+1): one start pulse -> FETCH
   task automatic do_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // from FETCH (called at posedge+1): present an instruction on cycle 0 and
   // raise alu_done / mem_ack on the given cycle index, for n cycles
   task automatic run_instr(input logic [5:0] op, input logic [7:0] c,
                            input logic [3:0] fl, input int n,
                            input int alu_at, input int ack_at);
      for (int k = 0; k < n; k++) begin
         instr_valid = (k == 0);
         opCode      = op;
         ctrl        = c;
         flags       = fl;
         alu_done    = (k == alu_at);
         mem_ack     = (k == ack_at);
         @(posedge clk); #1;
      end
      instr_valid = 1'b0;
      alu_done    = 1'b0;
      mem_ack     = 1'b0;
   endtask

   // noise on handshake inputs while the sequencer should ignore them
   task automatic poke_inputs(input int n);
      for (int k = 0; k < n; k++) begin
         start       = 1'b1;
         instr_valid = 1'b1;
         alu_done    = 1'b1;
         mem_ack     = 1'b1;
         @(posedge clk); #1;
      end
      start       = 1'b0;
      instr_valid = 1'b0;
      alu_done    = 1'b0;
      mem_ack     = 1'b0;
   endtask

   initial begin
      int w0;

      // reset state
      @(posedge clk); #1;
      chk("reset_outputs", {2'b0, all_out()}, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      chk("idle_after_reset", {29'b0, state}, 32'd0);
      @(posedge clk); #1;
      chk("idle_holds_without_start", {29'b0, state}, 32'd0);
      do_start();
      chk("start_to_fetch", {29'b0, state}, 32'd1);

      // add: FETCH, DECODE, EXEC, WB
      push(3'd1, S_IR, 16'd0);
      push(3'd3, S_ALU, 16'd0);
      push(3'd6, S_PCI | S_ACC, 16'd0);
      run_instr(6'd9, 8'hA4, 4'h0, 4, -1, -1);
      chk("add_back_to_fetch", {29'b0, state}, 32'd1);
      chk("add_retired", {16'b0, retired}, 32'd1);

      // cmp: no accumulator write
      push(3'd1, S_IR, 16'd1);
      push(3'd3, S_ALU, 16'd1);
      push(3'd6, S_PCI, 16'd1);
      run_instr(6'd23, 8'hA0, 4'h0, 4, -1, -1);

      // mul: 5 WAIT_ALU cycles, alu_done on the 5th
      w0 = wait_seen;
      push(3'd1, S_IR, 16'd2);
      push(3'd3, S_ALU, 16'd2);
      push(3'd6, S_PCI | S_ACC, 16'd2);
      run_instr(6'd16, 8'hA4, 4'h0, 9, 7, -1);
      chk("mul_wait_cycles", wait_seen - w0, 32'd5);
      chk("mul_back_to_fetch", {29'b0, state}, 32'd1);

      // brz taken (Z set)
      push(3'd1, S_IR, 16'd3);
      push(3'd2, S_PCL, 16'd3);
      run_instr(6'd0, 8'hC0, 4'b0001, 2, -1, -1);
      // brz not taken
      push(3'd1, S_IR, 16'd4);
      push(3'd2, S_PCI, 16'd4);
      run_instr(6'd0, 8'hC0, 4'b0000, 2, -1, -1);
      // brn taken (N set)
      push(3'd1, S_IR, 16'd5);
      push(3'd2, S_PCL, 16'd5);
      run_instr(6'd1, 8'hC0, 4'b0010, 2, -1, -1);
      // bro not taken (Z,N,C set, O clear)
      push(3'd1, S_IR, 16'd6);
      push(3'd2, S_PCI, 16'd6);
      run_instr(6'd3, 8'hC0, 4'b0111, 2, -1, -1);
      // jmp: pc_load and sp_op regardless of flags
      push(3'd1, S_IR, 16'd7);
      push(3'd2, S_PCL | S_SP, 16'd7);
      run_instr(6'd8, 8'hC3, 4'b0000, 2, -1, -1);
      chk("branch_back_to_fetch", {29'b0, state}, 32'd1);

      // load: mem_rd for 3 cycles, ack on the third, then WB
      push(3'd1, S_IR, 16'd8);
      push(3'd5, S_RD, 16'd8);
      push(3'd5, S_RD, 16'd8);
      push(3'd5, S_RD, 16'd8);
      push(3'd6, S_PCI | S_ACC, 16'd8);
      run_instr(6'd4, 8'hD8, 4'h0, 6, -1, 4);
      // store: mem_wr for 2 cycles, pc_inc with the ack, no WB
      push(3'd1, S_IR, 16'd9);
      push(3'd5, S_WR, 16'd9);
      push(3'd5, S_WR | S_PCI, 16'd9);
      run_instr(6'd5, 8'h90, 4'h0, 4, -1, 3);
      chk("store_back_to_fetch", {29'b0, state}, 32'd1);
      chk("retired_after_ten", {16'b0, retired}, 32'd10);

      // mul with alu_done withheld: timeout after 32 WAIT_ALU cycles
      w0 = wait_seen;
      push(3'd1, S_IR, 16'd10);
      push(3'd3, S_ALU, 16'd10);
      run_instr(6'd16, 8'hA4, 4'h0, 35, -1, -1);
      chk("timeout_wait_cycles", wait_seen - w0, 32'd32);
      chk("timeout_state_halt", {29'b0, state}, 32'd7);
      chk("timeout_halted_err", {30'b0, halted, err}, 32'd3);
      chk("timeout_no_retire", {16'b0, retired}, 32'd10);
      poke_inputs(3);
      chk("halt_ignores_inputs", {29'b0, state}, 32'd7);

      // reset clears sticky error; illegal opcode halts from DECODE
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("reset_clears_err", {2'b0, all_out()}, 32'h0);
      do_start();
      push(3'd1, S_IR, 16'd0);
      run_instr(6'h3F, 8'hFF, 4'h0, 1, -1, -1);
      chk("illegal_in_decode", {29'b0, state}, 32'd2);
      @(posedge clk); #1;
      chk("illegal_state_halt", {29'b0, state}, 32'd7);
      chk("illegal_halted_err", {30'b0, halted, err}, 32'd3);
      poke_inputs(3);
      chk("illegal_halt_holds", {29'b0, state}, 32'd7);
      chk("illegal_no_retire", {16'b0, retired}, 32'd0);

      // asynchronous reset in the middle of WAIT_ALU
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      do_start();
      push(3'd1, S_IR, 16'd0);
      push(3'd3, S_ALU, 16'd0);
      run_instr(6'd17, 8'hA4, 4'h0, 5, -1, -1);
      chk("mid_wait_state", {29'b0, state}, 32'd4);
      #2;
      rst = 1'b1;
      #1;
      chk("async_reset_outputs", {2'b0, all_out()}, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      do_start();
      push(3'd1, S_IR, 16'd0);
      push(3'd3, S_ALU, 16'd0);
      push(3'd6, S_PCI | S_ACC, 16'd0);
      run_instr(6'd9, 8'hA4, 4'h0, 4, -1, -1);
      chk("resume_retired", {16'b0, retired}, 32'd1);
      chk("resume_state_fetch", {29'b0, state}, 32'd1);

      @(posedge clk); #1;
      chk("expected_queue_drained", exp_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
